// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: 1 s timebase, sec/min counting and hour/minute increment pulses with a mode-set FSM
//   clk, rst        rising-edge clock, async active-high reset
//   i_mode          mode button level (debounced); each rising edge steps RUN->SET_HOUR->SET_MIN->RUN
//   i_set_inc       increment button level (debounced); acts only in the set modes
//   o_inc_hour      one-cycle pulse to advance the external hour counter
//   o_inc_min       one-cycle pulse whenever the minute count advances
//   o_sec, o_min    seconds and minutes, 0..59
//   o_mode          0=RUN, 1=SET_HOUR, 2=SET_MIN
module clock_time_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_mode,
  input  logic       i_set_inc,
  output logic       o_inc_hour,
  output logic       o_inc_min,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [1:0] o_mode
);
  typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2} mode_t;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  mode_t         state_q;
  logic [PW-1:0] pre_q;
  logic [5:0]    sec_q, min_q, min_inc;
  logic          mode_prev_q, set_prev_q, inc_hour_q, inc_min_q;
  logic          mode_edge, set_edge, tick;
  assign mode_edge = i_mode & ~mode_prev_q;
  // a mode edge swallows a coincident set edge and a coincident tick
  assign set_edge  = i_set_inc & ~set_prev_q & ~mode_edge;
  assign tick      = (state_q == RUN) & (pre_q == PMAX) & ~mode_edge;
  assign min_inc   = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      pre_q       <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      mode_prev_q <= 1'b0;
      set_prev_q  <= 1'b0;
      inc_hour_q  <= 1'b0;
      inc_min_q   <= 1'b0;
    end else begin
      mode_prev_q <= i_mode;
      set_prev_q  <= i_set_inc;
      inc_hour_q  <= 1'b0;
      inc_min_q   <= 1'b0;
      // prescaler runs only while staying in RUN; otherwise parked at 0 so RUN re-entry waits a full period
      pre_q       <= (state_q == RUN && !mode_edge && !tick) ? pre_q + 1'b1 : '0;
      if (mode_edge) begin
        case (state_q)
          RUN: begin
            state_q <= SET_HOUR;
            sec_q   <= '0;
          end
          SET_HOUR: state_q <= SET_MIN;
          default:  state_q <= RUN;
        endcase
      end else if (tick) begin
        sec_q <= (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
        if (sec_q == 6'd59) begin
          min_q      <= min_inc;
          inc_min_q  <= 1'b1;
          inc_hour_q <= (min_q == 6'd59);
        end
      end else if (set_edge && state_q == SET_HOUR) begin
        inc_hour_q <= 1'b1;
      end else if (set_edge && state_q == SET_MIN) begin
        min_q     <= min_inc;
        inc_min_q <= 1'b1;
      end
    end
  end
  assign o_inc_hour = inc_hour_q;
  assign o_inc_min  = inc_min_q;
  assign o_sec      = sec_q;
  assign o_min      = min_q;
  assign o_mode     = state_q;
endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl: directed scenarios plus random button traffic checked cycle by cycle against a time-of-day model
module tb_clock_time_ctrl;
  localparam int TD = 4;
  logic       clk = 1'b0, rst = 1'b0, i_mode = 1'b0, i_set_inc = 1'b0;
  logic       o_inc_hour, o_inc_min;
  logic [5:0] o_sec, o_min;
  logic [1:0] o_mode;
  int total = 0, bad = 0;
  int m_mode, m_phase, m_total, ih_cnt, im_cnt;
  bit m_mp, m_sp, exp_ih, exp_im;

  clock_time_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .i_mode(i_mode), .i_set_inc(i_set_inc),
    .o_inc_hour(o_inc_hour), .o_inc_min(o_inc_min),
    .o_sec(o_sec), .o_min(o_min), .o_mode(o_mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // time of day held as seconds since 00:00 within the hour, 0..3599
  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_total = 0; m_mp = 0; m_sp = 0; exp_ih = 0; exp_im = 0;
  endtask

  task automatic model_step(input bit m, input bit s);
    bit me, se;
    me = m && !m_mp;
    se = s && !m_sp && !me;
    exp_ih = 0; exp_im = 0;
    if (me) begin
      if (m_mode == 0) m_total -= m_total % 60;
      m_mode = (m_mode + 1) % 3;
      m_phase = 0;
    end else if (m_mode == 0) begin
      m_phase++;
      if (m_phase == TD) begin
        m_phase = 0;
        m_total = (m_total + 1) % 3600;
        exp_im = (m_total % 60 == 0);
        exp_ih = (m_total == 0);
      end
    end else if (se && m_mode == 1) begin
      exp_ih = 1;
    end else if (se && m_mode == 2) begin
      m_total = ((m_total / 60 + 1) % 60) * 60 + m_total % 60;
      exp_im = 1;
    end
    m_mp = m; m_sp = s;
  endtask

  task automatic step(input bit m, input bit s);
    i_mode = m; i_set_inc = s;
    @(posedge clk);
    model_step(m, s);
    #1;
    chk("sec", o_sec, m_total % 60);
    chk("min", o_min, m_total / 60);
    chk("mode", o_mode, m_mode);
    chk("inc_hour", o_inc_hour, exp_ih);
    chk("inc_min", o_inc_min, exp_im);
    ih_cnt += o_inc_hour;
    im_cnt += o_inc_min;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_sec", o_sec, 0);
    chk("rst_mode", o_mode, 0);
    chk("rst_pulse", {o_inc_hour, o_inc_min}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // minute roll-over
    ih_cnt = 0; im_cnt = 0;
    idle(240);
    chk("t1_min", o_min, 1);
    chk("t1_sec", o_sec, 0);
    chk("t1_im_cnt", im_cnt, 1);
    chk("t1_ih_cnt", ih_cnt, 0);
    // hour roll-over
    idle(14396 - 240);
    chk("t2_pre_min", o_min, 59);
    chk("t2_pre_sec", o_sec, 59);
    ih_cnt = 0; im_cnt = 0;
    idle(TD);
    chk("t2_ih_cnt", ih_cnt, 1);
    chk("t2_im_cnt", im_cnt, 1);
    chk("t2_min", o_min, 0);
    // mode cycling and prescaler restart
    idle(20);
    chk("t3_sec_run", o_sec, 5);
    step(1, 0);
    chk("t3_mode1", o_mode, 1);
    chk("t3_sec_clr", o_sec, 0);
    step(0, 0); step(1, 0);
    chk("t3_mode2", o_mode, 2);
    step(0, 0); step(1, 0);
    chk("t3_mode0", o_mode, 0);
    idle(TD - 1);
    chk("t3_no_tick", o_sec, 0);
    idle(1);
    chk("t3_tick", o_sec, 1);
    // hour set, one press held
    step(1, 0); step(0, 0);
    ih_cnt = 0; im_cnt = 0;
    step(0, 1); step(0, 0);
    for (int i = 0; i < 10; i++) step(0, 1);
    step(0, 0); step(0, 1); step(0, 0);
    chk("t4_ih_cnt", ih_cnt, 3);
    chk("t4_im_cnt", im_cnt, 0);
    chk("t4_min", o_min, 0);
    // minute set through wrap, then simultaneous edges
    step(1, 0); step(0, 0);
    for (int k = 0; k < 60 && m_total / 60 != 59; k++) begin step(0, 1); step(0, 0); end
    chk("t5_pre_min", o_min, 59);
    ih_cnt = 0; im_cnt = 0;
    step(0, 1); step(0, 0);
    chk("t5_min_wrap", o_min, 0);
    chk("t5_im_cnt", im_cnt, 1);
    chk("t5_ih_cnt", ih_cnt, 0);
    step(1, 1);
    chk("t5_both_mode", o_mode, 0);
    chk("t5_both_im_cnt", im_cnt, 1);
    step(0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    // async reset during an hour pulse
    step(0, 0);
    while (m_mode != 1) step(m_mp ? 1'b0 : 1'b1, 1'b0);
    step(0, 0); step(0, 1);
    chk("t6_pulse_hi", o_inc_hour, 1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_ih", o_inc_hour, 0);
    chk("t6_sec", o_sec, 0);
    chk("t6_min", o_min, 0);
    chk("t6_mode", o_mode, 0);
    i_set_inc = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2 * TD);
    chk("t6_resume", o_sec, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
